mem_access_stage: RTL and testbench

- Consumer end of the EXE/MEM pipeline register. Takes the registered mem_* control/data bundle and drives a req/ack data-memory port.
- Stalls the upstream pipeline while a load/store is outstanding.
- Selects the writeback value (load data, ALU result or move operand) and registers it into the MEM/WB stage.
- Sits between the EXE/MEM register and the writeback stage / register file.

---
 rtl/mem_access_stage_pkg.sv | 37 +++
 rtl/mem_access_stage_if.sv | 41 ++++
 rtl/mem_access_stage_mem_wb.sv | 49 ++++
 rtl/mem_access_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_pkg
// Purpose  : Shared types and constants for the memory-access pipeline stage.
//            Holds the access FSM encoding, polarity constants for the
//            EXE/MEM control bundle and the default access timeout.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    localparam int          REG_W             = 32;
    localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;

    localparam logic        RST_ENABLE        = 1'b1;
    localparam logic        READ_ENABLE       = 1'b1;
    localparam logic        WRITE_ENABLE      = 1'b1;
    localparam logic        LW_ALU_SRC        = 1'b1;  // writeback from load data
    localparam logic        MV_ALU_SRC        = 1'b1;  // writeback from move operand
    localparam logic        MEM_STALL_ENABLE  = 1'b1;
    localparam logic        MEM_STALL_DISABLE = 1'b0;

    localparam int          TIMEOUT_DEFAULT   = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Word accesses only: the two address LSBs must be zero.
    function automatic logic is_aligned(input logic [REG_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : mem_access_stage_pkg
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_if
// Purpose  : Request/acknowledge data-memory port.
// Ports    : dm_req   - request, held until completion (master -> slave)
//            dm_we    - 1 = write, 0 = read, valid with dm_req
//            dm_addr  - word address
//            dm_wdata - store data
//            dm_rdata - load data, valid with dm_ack (slave -> master)
//            dm_ack   - one-cycle completion strobe
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ack
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_rdata,
        output dm_ack
    );

endinterface : mem_access_stage_if
`default_nettype wire

// File: rtl/mem_access_stage_mem_wb.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_reg
// Purpose  : MEM/WB pipeline register. The valid bit is refreshed every
//            cycle; data and tag only load when a retiring instruction is
//            presented, so a bubble leaves the last retired entry in place.
// Ports    : clk, rst     - clock, asynchronous active-high reset
//            valid_i      - entry being presented is a retired instruction
//            data_i/tag_i - writeback value and tag to capture
//            wb_data_o, wb_tag_o, wb_valid_o - registered MEM/WB entry
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_reg
    import mem_access_stage_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              valid_i,
    input  wire logic [REG_W-1:0]  data_i,
    input  wire logic [REG_W-1:0]  tag_i,
    output logic      [REG_W-1:0]  wb_data_o,
    output logic      [REG_W-1:0]  wb_tag_o,
    output logic                   wb_valid_o
);

    logic [REG_W-1:0] data_q;
    logic [REG_W-1:0] tag_q;
    logic             valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            data_q  <= ZERO_WORD;
            tag_q   <= ZERO_WORD;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
                tag_q  <= tag_i;
            end
        end
    end

    assign wb_data_o  = data_q;
    assign wb_tag_o   = tag_q;
    assign wb_valid_o = valid_q;

endmodule : mem_wb_reg
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : Consumer end of the EXE/MEM register. Issues word loads/stores
//            on the dm port, stalls upstream while an access is outstanding,
//            aborts an access that is never acknowledged, and selects the
//            writeback value captured into MEM/WB.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            mem_*           - EXE/MEM control/data bundle (inputs)
//            dm              - data-memory req/ack port (master side)
//            mem_stall       - freeze PC/IF/ID/EXE and EXE/MEM
//            mem_misalign    - one-cycle pulse on a suppressed misaligned access
//            dm_err          - sticky access-timeout flag
//            wb_data, wb_write_o, wb_valid - MEM/WB entry
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [REG_W-1:0]  mem_sw_o,
    input  wire logic [REG_W-1:0]  mem_write_o,
    input  wire logic              mem_lwsrc,
    input  wire logic              mem_movsrc,
    input  wire logic              mem_DM_read,
    input  wire logic              mem_DM_write,
    input  wire logic [REG_W-1:0]  mem_alu_result,
    mem_access_stage_if.master     dm,
    output logic                   mem_stall,
    output logic                   mem_misalign,
    output logic                   dm_err,
    output logic      [REG_W-1:0]  wb_data,
    output logic      [REG_W-1:0]  wb_write_o,
    output logic                   wb_valid
);

    // Counter value on the last BUSY cycle before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_t       state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [REG_W-1:0] addr_q, addr_d;
    logic [REG_W-1:0] wdata_q, wdata_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [REG_W-1:0] lbuf_q, lbuf_d;
    logic             err_q, err_d;

    logic             stall_w;
    logic             misalign_w;
    logic             wb_valid_d;
    logic [REG_W-1:0] wb_data_d;

    logic             access_w;
    logic             aligned_w;
    logic [REG_W-1:0] alu_or_mov_w;

    assign access_w     = (mem_DM_read == READ_ENABLE) || (mem_DM_write == WRITE_ENABLE);
    assign aligned_w    = is_aligned(mem_alu_result);
    assign alu_or_mov_w = (mem_movsrc == MV_ALU_SRC) ? mem_sw_o : mem_alu_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= ZERO_WORD;
            wdata_q <= ZERO_WORD;
            cnt_q   <= 8'd0;
            lbuf_q  <= ZERO_WORD;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            lbuf_q  <= lbuf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        lbuf_d     = lbuf_q;
        err_d      = err_q;
        stall_w    = MEM_STALL_DISABLE;
        misalign_w = 1'b0;
        wb_valid_d = 1'b0;
        wb_data_d  = mem_alu_result;

        case (state_q)
            IDLE: begin
                if (access_w && !aligned_w) begin
                    // Suppressed access retires like an ALU op on the address.
                    misalign_w = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_data_d  = mem_alu_result;
                end else if (access_w) begin
                    stall_w = MEM_STALL_ENABLE;
                    req_d   = 1'b1;
                    we_d    = (mem_DM_write == WRITE_ENABLE);  // write wins over read
                    addr_d  = mem_alu_result;
                    wdata_d = mem_sw_o;
                    cnt_d   = 8'd0;
                    state_d = BUSY;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = alu_or_mov_w;
                end
            end

            BUSY: begin
                stall_w = MEM_STALL_ENABLE;
                if (dm.dm_ack) begin
                    // Stores leave the load buffer untouched.
                    if (!we_q) begin
                        lbuf_d = dm.dm_rdata;
                    end
                    req_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    lbuf_d  = ZERO_WORD;
                    req_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DONE: begin
                wb_valid_d = 1'b1;
                wb_data_d  = (mem_lwsrc == LW_ALU_SRC) ? lbuf_q : alu_or_mov_w;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (wb_valid_d),
        .data_i     (wb_data_d),
        .tag_i      (mem_write_o),
        .wb_data_o  (wb_data),
        .wb_tag_o   (wb_write_o),
        .wb_valid_o (wb_valid)
    );

    // Combinational outputs are forced low while reset is held so that a
    // reset during an access releases the pipeline immediately.
    assign mem_stall    = stall_w && (rst != RST_ENABLE);
    assign mem_misalign = misalign_w && (rst != RST_ENABLE);
    assign dm_err       = err_q;

    assign dm.dm_req    = req_q;
    assign dm.dm_we     = we_q;
    assign dm.dm_addr   = addr_q;
    assign dm.dm_wdata  = wdata_q;

endmodule : mem_access_stage
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Scoreboard bench for mem_access_stage. Stimulus pushes the
//            expected MEM/WB entry; a monitor pops and compares every
//            retired entry. A second instance with a short timeout and a
//            memory that never acknowledges exercises the abort path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [31:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main DUT stimulus / observation
    logic [31:0] sw, tag, alu;
    logic        lw, mv, rd, wr;
    logic        stall, misal, err, wbv;
    logic [31:0] wbd, wbt;

    mem_access_stage_if dm ();
    logic        r_ack, force_ack;
    logic [31:0] rdata;
    assign dm.dm_ack   = r_ack | force_ack;
    assign dm.dm_rdata = rdata;

    mem_access_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_sw_o       (sw),
        .mem_write_o    (tag),
        .mem_lwsrc      (lw),
        .mem_movsrc     (mv),
        .mem_DM_read    (rd),
        .mem_DM_write   (wr),
        .mem_alu_result (alu),
        .dm             (dm),
        .mem_stall      (stall),
        .mem_misalign   (misal),
        .dm_err         (err),
        .wb_data        (wbd),
        .wb_write_o     (wbt),
        .wb_valid       (wbv)
    );

    // Timeout instance: memory never acknowledges, returns all-ones data.
    logic [31:0] alu2;
    logic        rd2;
    logic        stall2, mis2, err2, wbv2;
    logic [31:0] wbd2, wbt2;

    mem_access_stage_if dm2 ();
    assign dm2.dm_ack   = 1'b0;
    assign dm2.dm_rdata = 32'hFFFF_FFFF;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk            (clk),
        .rst            (rst),
        .mem_sw_o       (32'h0),
        .mem_write_o    (32'h0),
        .mem_lwsrc      (1'b1),
        .mem_movsrc     (1'b0),
        .mem_DM_read    (rd2),
        .mem_DM_write   (1'b0),
        .mem_alu_result (alu2),
        .dm             (dm2),
        .mem_stall      (stall2),
        .mem_misalign   (mis2),
        .dm_err         (err2),
        .wb_data        (wbd2),
        .wb_write_o     (wbt2),
        .wb_valid       (wbv2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Per-cycle activity counters, sampled on the falling edge.
    int          stall_cyc, req_cyc, mis_cyc, nov_cyc, req2_cyc;
    logic [31:0] seen_addr, seen_wdata;
    logic        seen_we;

    always @(negedge clk) begin
        if (stall) stall_cyc++;
        if (misal) mis_cyc++;
        if (!wbv)  nov_cyc++;
        if (dm2.dm_req) req2_cyc++;
        if (dm.dm_req) begin
            if (req_cyc == 0) begin
                seen_addr  = dm.dm_addr;
                seen_wdata = dm.dm_wdata;
                seen_we    = dm.dm_we;
            end
            req_cyc++;
        end
    end

    task automatic clr_counters();
        stall_cyc = 0; req_cyc = 0; mis_cyc = 0; nov_cyc = 0;
        seen_addr = 32'hX; seen_wdata = 32'hX; seen_we = 1'bX;
    endtask

    // Memory responder: acks on request cycle number ack_delay (0 = first).
    logic        ack_en = 1'b0;
    int          ack_delay = 0;
    logic [31:0] ack_data = 32'h0;
    int          req_n = 0;

    always @(negedge clk) begin
        rdata = ack_data;
        if (dm.dm_req && ack_en) begin
            r_ack = (req_n == ack_delay);
            req_n++;
        end else begin
            r_ack = 1'b0;
            req_n = 0;
        end
    end

    // Scoreboard monitor
    exp_t exp_q[$];
    exp_t e;
    logic mon_en = 1'b1;

    always @(negedge clk) begin
        if (mon_en && !rst && wbv) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL wb_unexpected: got data %h tag %h, expected no entry", wbd, wbt);
            end else begin
                e = exp_q.pop_front();
                chk("wb_data", wbd, e.data);
                chk("wb_write_o", wbt, e.tag);
            end
        end
    end

    // Present one instruction and hold it until the stage accepts it.
    // Returns just after the accepting rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] s, input logic [31:0] t,
                         input logic l, input logic m, input logic r, input logic w,
                         input logic [31:0] exp_d);
        alu = a; sw = s; tag = t; lw = l; mv = m; rd = r; wr = w;
        exp_q.push_back('{data: exp_d, tag: t});
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!stall) break;
            if (i == 399) begin
                n_chk++;
                n_fail++;
                $display("FAIL issue_budget: mem_stall still %b after 400 cycles, expected 0", stall);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic [31:0] t);
        issue(32'h0, 32'h0, t, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int iters;
        rst = 1'b1; force_ack = 1'b0; r_ack = 1'b0; rdata = 32'h0;
        sw = 0; tag = 0; alu = 0; lw = 0; mv = 0; rd = 0; wr = 0;
        alu2 = 0; rd2 = 0;
        clr_counters();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dm_req",   {31'h0, dm.dm_req}, 32'h0);
        chk("rst_dm_we",    {31'h0, dm.dm_we},  32'h0);
        chk("rst_dm_addr",  dm.dm_addr,  32'h0);
        chk("rst_dm_wdata", dm.dm_wdata, 32'h0);
        chk("rst_wb_data",  wbd, 32'h0);
        chk("rst_wb_valid", {31'h0, wbv},   32'h0);
        chk("rst_misalign", {31'h0, misal}, 32'h0);
        chk("rst_dm_err",   {31'h0, err},   32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU op and move op: one cycle each, never stall.
        clr_counters();
        issue(32'h0000_1234, 32'h9999_9999, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1234);
        chk("alu_stall_cycles", stall_cyc, 0);
        chk("alu_req_cycles",   req_cyc,   0);
        issue(32'h0000_1111, 32'hCAFE_F00D, 32'h2, 1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D);

        // Load at 0x100, ack on first request cycle.
        ack_en = 1'b1; ack_delay = 0; ack_data = 32'hDEAD_BEEF;
        clr_counters();
        issue(32'h0000_0100, 32'h0, 32'h3, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("ld_stall_cycles", stall_cyc, 2);
        chk("ld_req_cycles",   req_cyc,   1);
        chk("ld_dm_addr",      seen_addr, 32'h0000_0100);
        chk("ld_dm_we",        {31'h0, seen_we}, 32'h0);
        chk("ld_novalid_cycles", nov_cyc, 2);

        // Store at 0x204, ack after five extra cycles.
        ack_delay = 5; ack_data = 32'h1111_2222;
        clr_counters();
        issue(32'h0000_0204, 32'hA5A5_A5A5, 32'h4, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0204);
        chk("st_req_cycles",   req_cyc,   6);
        chk("st_stall_cycles", stall_cyc, 7);
        chk("st_dm_we",        {31'h0, seen_we}, 32'h1);
        chk("st_dm_wdata",     seen_wdata, 32'hA5A5_A5A5);
        chk("st_novalid_cycles", nov_cyc, 7);

        // Store selecting load data: the buffer still holds the last load.
        ack_delay = 0; ack_data = 32'h3333_3333;
        issue(32'h0000_0208, 32'h5A5A_5A5A, 32'h5, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Read and write together: the write wins.
        clr_counters();
        issue(32'h0000_020C, 32'h0BAD_CAFE, 32'h6, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_020C);
        chk("rw_dm_we",    {31'h0, seen_we}, 32'h1);
        chk("rw_dm_wdata", seen_wdata, 32'h0BAD_CAFE);

        // Misaligned load: suppressed, retires the address.
        clr_counters();
        issue(32'h0000_0102, 32'h0000_0077, 32'h7, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0102);
        chk("mis_pulse_cycles", mis_cyc,   1);
        chk("mis_req_cycles",   req_cyc,   0);
        chk("mis_stall_cycles", stall_cyc, 0);
        ack_en = 1'b0;

        // Timeout instance: load with no ack, main DUT idles with NOPs.
        rd2 = 1'b1; alu2 = 32'h0000_0080; req2_cyc = 0; iters = 0;
        for (int i = 0; i < 20; i++) begin
            nop(32'h50 + i);
            iters++;
            if (wbv2) break;
        end
        rd2 = 1'b0;
        chk("to_iterations",  iters,    6);
        chk("to_req_cycles",  req2_cyc, 4);
        chk("to_dm_err",      {31'h0, err2}, 32'h1);
        chk("to_wb_data",     wbd2, 32'h0);
        rd2 = 1'b1; alu2 = 32'h0000_0081;
        nop(32'h70);
        rd2 = 1'b0;
        nop(32'h71);
        chk("to_err_sticky",  {31'h0, err2}, 32'h1);
        chk("main_dm_err",    {31'h0, err},  32'h0);

        // Reset in the middle of a BUSY access.
        alu = 32'h0000_0300; sw = 0; tag = 32'h60; lw = 1; mv = 0; rd = 1; wr = 0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_busy_dm_req",   {31'h0, dm.dm_req}, 32'h0);
        chk("rst_busy_stall",    {31'h0, stall},     32'h0);
        chk("rst_busy_wb_valid", {31'h0, wbv},       32'h0);
        chk("rst_clears_err",    {31'h0, err2},      32'h0);
        rd = 0; lw = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Late acknowledge in IDLE is ignored.
        force_ack = 1'b1; ack_data = 32'hBAD0_BAD0;
        clr_counters();
        issue(32'h0000_0077, 32'h0, 32'h61, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0077);
        force_ack = 1'b0;
        chk("late_ack_stall", stall_cyc, 0);
        chk("late_ack_req",   req_cyc,   0);

        // Next load completes normally.
        ack_en = 1'b1; ack_delay = 1; ack_data = 32'h1357_9BDF;
        clr_counters();
        issue(32'h0000_0400, 32'h0, 32'h62, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1357_9BDF);
        chk("post_rst_req_cycles",   req_cyc,   2);
        chk("post_rst_stall_cycles", stall_cyc, 3);
        chk("post_rst_dm_addr",      seen_addr, 32'h0000_0400);

        @(negedge clk); #1;
        mon_en = 1'b0;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mem_access_stage
`default_nettype wire
